// File: rtl/romix_pkg.sv
// romix_pkg: shared types, defaults and helpers for the multi-ROMix array
//   arb_state_e    : BlockMix arbiter FSM encoding (ARB, LAUNCH, RUN, RESP)
//   DATA_W_DEFAULT : BlockMix block width in bits for r=1
//   wrap_add       : (v + k) mod n, used for round-robin pointer arithmetic
package romix_pkg;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   localparam int DATA_W_DEFAULT = 1024;

   function automatic int wrap_add(input int v, input int k, input int n);
      return (v + k) % n;
   endfunction

endpackage

// File: rtl/romix_blockmix_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker, first set request at or after rr_ptr
//   req    : request vector, one bit per requester
//   rr_ptr : index with highest priority this round (must be < N_REQ)
//   found  : any request pending
//   idx    : chosen requester, valid when found=1
module rr_priority_pick
   import romix_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (req[wrap_add(int'(rr_ptr), k, N_REQ)]) idx = IDX_W'(wrap_add(int'(rr_ptr), k, N_REQ));
   end

   assign found = |req;

endmodule

// File: rtl/romix_blockmix_arbiter.sv
// romix_blockmix_arbiter: round-robin sharing of one BlockMix core among N_REQ ROMix controllers
//   clk, reset_n    : clock (rising edge), asynchronous active-low reset
//   req, req_data   : per-controller level request and input block (slice i at i*DATA_W)
//   blockmix_valid  : one-cycle completion pulse to the granted controller
//   rsp_data        : result block broadcast to all controllers, held until the next capture
//   bm_start        : one-cycle start pulse to the shared core
//   bm_data_in      : registered block presented to the core
//   bm_valid        : core done pulse; bm_data_out valid with it
//   grant_idx       : current or most recent grant
//   busy            : high whenever the FSM is outside ARB
//   err_timeout     : sticky watchdog error, cleared only by reset
module romix_blockmix_arbiter
   import romix_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        blockmix_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    bm_start,
   output logic [DATA_W-1:0]       bm_data_in,
   input  logic                    bm_valid,
   input  logic [DATA_W-1:0]       bm_data_out,
   output logic [IDX_W-1:0]        grant_idx,
   output logic                    busy,
   output logic                    err_timeout
);

   localparam int WD_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

   arb_state_e        state_q;
   logic [IDX_W-1:0]  rr_q;
   logic [IDX_W-1:0]  grant_q;
   logic              start_q;
   logic [N_REQ-1:0]  valid_q;
   logic              busy_q;
   logic              err_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] rsp_q;
   logic [WD_W-1:0]   wd_q;
   logic              pick_found_d;
   logic [IDX_W-1:0]  pick_idx_d;
   logic [DATA_W-1:0] slice [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign slice[i] = req_data[i*DATA_W +: DATA_W];
   end

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_q),
      .found  (pick_found_d),
      .idx    (pick_idx_d)
   );

   // bm_start is raised while in LAUNCH so it reaches the core in the first RUN
   // cycle. The completion pulse is decided at the bm_valid edge so it is seen
   // during RESP, together with the freshly captured rsp_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB;
         rr_q    <= '0;
         grant_q <= '0;
         start_q <= 1'b0;
         valid_q <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         din_q   <= '0;
         rsp_q   <= '0;
         wd_q    <= '0;
      end else begin
         start_q <= 1'b0;
         valid_q <= '0;
         case (state_q)
            ARB: begin
               if (pick_found_d) begin
                  grant_q <= pick_idx_d;
                  din_q   <= slice[pick_idx_d];
                  busy_q  <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               start_q <= 1'b1;
               wd_q    <= '0;
               state_q <= RUN;
            end
            RUN: begin
               if (bm_valid) begin
                  rsp_q   <= bm_data_out;
                  valid_q <= req[grant_q] ? (N_REQ'(1) << grant_q) : '0;
                  state_q <= RESP;
               end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            RESP: begin
               rr_q    <= IDX_W'(wrap_add(int'(grant_q), 1, N_REQ));
               busy_q  <= 1'b0;
               state_q <= ARB;
            end
            default: state_q <= ARB;
         endcase
      end
   end

   assign blockmix_valid = valid_q;
   assign rsp_data       = rsp_q;
   assign bm_start       = start_q;
   assign bm_data_in     = din_q;
   assign grant_idx      = grant_q;
   assign busy           = busy_q;
   assign err_timeout    = err_q;

endmodule

// File: doc/romix_blockmix_arbiter.md
Name: romix_blockmix_arbiter

Overview:
- Shares one BlockMix (Salsa20/8) core between N ROMix controllers in the multi-ROMix array.
- Each controller raises its blockmix_en as a level request and waits for a one-cycle blockmix_valid. The arbiter grants requesters round-robin, launches the shared core, and returns the result to the granted controller.
- A watchdog flags a hung core.

Parameters:
- N_REQ, 4, number of ROMix controllers sharing the core (2..8).
- DATA_W, 1024, BlockMix block width in bits (r=1).
- IDX_W, 2, grant index width; must equal clog2(N_REQ).
- TIMEOUT, 1024, max cycles from bm_start to bm_valid before err_timeout is set.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-controller blockmix_en level request.
- req_data  in  N_REQ*DATA_W  per-controller input block; slice i is [i*DATA_W +: DATA_W].
- blockmix_valid  out  N_REQ  one-cycle completion pulse to each controller.
- rsp_data  out  DATA_W  result block, broadcast to all controllers.
- bm_start  out  1  one-cycle start pulse to the shared core.
- bm_data_in  out  DATA_W  registered input block to the core.
- bm_valid  in  1  one-cycle done pulse from the core.
- bm_data_out  in  DATA_W  core result, valid when bm_valid=1.
- grant_idx  out  IDX_W  index of the current or most recent grant.
- busy  out  1  high in every state except ARB.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (async, reset_n=0): all of the following clear to 0 immediately:
  - state to ARB
  - rr_ptr, grant_idx
  - bm_start, blockmix_valid, busy, err_timeout
  - bm_data_in, rsp_data
  - watchdog counter
- Reset mid-job: any job in flight is abandoned. A later stray bm_valid arriving in ARB is ignored.
- FSM states: ARB, LAUNCH, RUN, RESP.
- ARB:
  - If req != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - Register grant_idx and bm_data_in <= req_data slice. Go to LAUNCH.
  - If req == 0, stay in ARB.
- LAUNCH:
  - bm_start=1 for exactly this cycle. Clear the watchdog. Go to RUN.
- RUN:
  - The watchdog increments each cycle.
  - On bm_valid: rsp_data <= bm_data_out, go to RESP.
  - If the watchdog reaches TIMEOUT-1 without bm_valid: set err_timeout and stay in RUN. Only reset clears err_timeout.
  - bm_valid and the timeout in the same cycle: bm_valid wins and err_timeout is not set.
- RESP:
  - If req[grant_idx]=1: blockmix_valid[grant_idx]=1 for this cycle only.
  - If req[grant_idx]=0 (requester withdrew): no pulse; the result is discarded.
  - rr_ptr <= grant_idx+1 mod N_REQ. Go to ARB.
- No grant is issued in the RESP cycle. This matters because the controller still holds blockmix_en while it sees blockmix_valid; its next request is therefore arbitrated only from the following ARB cycle, so a single pulse is never double-counted.
- Latency:
  - req rise in idle ARB → bm_start: 2 cycles.
  - bm_valid → blockmix_valid: 1 cycle.
  - Back-to-back grant overhead: 3 cycles (ARB, LAUNCH, RESP).
- rsp_data holds its value until the next bm_valid capture. Controllers sample it in the cycle their blockmix_valid pulse is high.
- Fairness: with all N_REQ requesting continuously, each is served once per N_REQ grants.
- bm_valid outside RUN: ignored and no state change.
- blockmix_valid is at most one-hot.

Decomposition:
- Shared package romix_pkg holds:
  - state encoding constants (ARB=2'd0, LAUNCH=2'd1, RUN=2'd2, RESP=2'd3)
  - DATA_W default
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: req, rr_ptr. Outputs: found, idx.
  - Also usable later for memory-port sharing.
- Watchdog counter and FSM stay in the top module.

Test Plan:
- Bench parameters: N_REQ=4, DATA_W=16, TIMEOUT=16.
- Single requester: req=4'b0100, slice2=16'hA5A5, core returns 16'h5A5A 5 cycles after bm_start → bm_start 2 cycles after req, bm_data_in=16'hA5A5; blockmix_valid=4'b0100 one cycle after bm_valid; rsp_data=16'h5A5A; grant_idx=2.
- Round-robin: req=4'b1111 held, core latency 3 → grant order 0,1,2,3,0; each controller drops and re-raises req per the ROMix handshake; no blockmix_valid wider than one cycle.
- Held-enable re-request: requester 1 keeps req high across its pulse (S5→S6 style) → exactly one blockmix_valid per bm_start; second grant begins in the ARB after RESP.
- Withdrawn request: req[3] drops during RUN → no blockmix_valid pulse; rr_ptr advances to 0; next grant to the lowest pending index ≥ 0.
- Watchdog: core never returns → err_timeout=1 at 16 cycles after bm_start; busy stays 1; reset_n=0 clears err_timeout, busy and state asynchronously.
- Reset mid-RUN, then a stray bm_valid in ARB → no pulse; next req served normally with fresh data.
